pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the motor PWM generator: measures an incoming PWM waveform's period and high time in clk cycles.
- Converts the measurement to a 10-bit duty code on the same 0..1023 scale the generator's duty input uses (duty = high*1024/period).
- Used for loop-back checking of the motor PWM, and for reading PWM-coded sensor or encoder feedback into the control FSM.

Parameters:
- CNT_W, 16, width of the period/high counters and outputs (4000 counts = 25 kHz at 100 MHz).
- TIMEOUT, 50000, cycles without a rising edge before the input is declared stalled; must be < 2^CNT_W and > 13.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous, active-high reset
- en  input  1  capture enable
- pwm_in  input  1  asynchronous PWM input
- period  output  CNT_W  last measured period, clk cycles
- high_time  output  CNT_W  last measured high time, clk cycles
- duty  output  10  floor(high_time*1024/period), saturated to 1023
- valid  output  1  one-cycle pulse: period/high_time/duty updated
- stalled  output  1  level: no rising edge within TIMEOUT
- busy  output  1  divider running

Behaviour:
- Reset, sampled on posedge clk: all outputs 0; state WAIT_EDGE; counters and synchronizer cleared.
- Input path: 2-flop synchronizer to pwm_s, plus a delay register pwm_d; rise = pwm_s & ~pwm_d.
- WAIT_EDGE: on rise, cnt<=1, hi_cnt<=1, go to MEASURE. Does not emit valid, so the first partial period is discarded.
- MEASURE and DIVIDE (counting phase):
  - cnt increments every cycle; hi_cnt increments when pwm_s=1.
  - On rise: latch period_r=cnt and high_r=hi_cnt, reload cnt<=1 and hi_cnt<=1.
  - If the state is MEASURE, go to DIVIDE.
  - If the state is already DIVIDE, the new sample is dropped. Counters still reload, so the next period is measured correctly.
- DIVIDE:
  - Restoring divide, one quotient bit per cycle. Numerator = high_r<<10 (CNT_W+10 bits), denominator = period_r.
  - 11 quotient bits, 11 cycles; busy=1 throughout.
  - Quotient 1024 (100% high) saturates to 1023.
  - The cycle after the last iteration: period, high_time and duty register, valid=1 for one cycle, stalled<=0, return to MEASURE.
  - Latency: rise detection to valid = 12 cycles; pwm_in pin edge to valid = 15 cycles.
  - Minimum supported period is 13 cycles; shorter periods drop samples.
- Timeout: in MEASURE, if cnt reaches TIMEOUT:
  - stalled<=1, period<=0, high_time<=0.
  - duty<=(pwm_s ? 1023 : 0).
  - valid pulses once; state goes to WAIT_EDGE.
  - The timeout sets stalled; only a later valid measurement clears it.
  - Counters never wrap.
- Timeout reached while in DIVIDE is deferred: the divide completes first.
- en=0, in any state and in the same cycle:
  - State goes to WAIT_EDGE; an in-progress divide is aborted with no valid.
  - Counters clear; busy=0.
  - period, high_time, duty and stalled hold their values.
- Rise and timeout in the same cycle: the rise wins and the measurement proceeds.
- rst mid-divide: reset wins; no valid.

Optional Feature:
- Macro: PWM_CAPTURE_AVG_EN.
- When defined:
  - duty reports the 4-sample moving average of raw duty codes, floor(sum/4), using a 12-bit sum.
  - The history fills with the first raw sample after reset, en fall or timeout.
  - Timeout results bypass the average and reload the history.
  - valid is delayed 1 cycle, so latency is 13 cycles from rise.
- When undefined: duty is the raw per-period code and there is no extra latency.

Test Plan:
- rst, en=1; drive a period of 4000 cycles with 2831 high, 3 periods -> first valid after the second rise; period=4000, high_time=2831, duty=724; valid repeats every 4000 cycles; stalled=0.
- Period 100, high 50 -> duty=512. Period 100, high 99 -> duty=1013. High 100 with no low gap -> held-high timeout path.
- pwm_in held 1 for >50000 cycles after a valid measurement -> exactly one valid with stalled=1, duty=1023, period=0; then a normal waveform -> stalled clears on the next valid.
- pwm_in held 0 -> a single valid with duty=0, stalled=1; no further valid pulses.
- en dropped mid-period, then raised -> no valid while low; outputs hold; first valid is one full period after the first post-enable rise.
- rst asserted during busy=1 -> the next cycle has all outputs 0, no valid. Separately: period 10 (below the minimum) -> samples dropped, no hang, valid only for completed divides.

Source files
------------

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control and measurement bundle between a PWM capture unit and its consumer.
// The capture unit takes the slave side; the controller (or bench) takes the master side.
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [9:0]       duty;
    logic             valid;
    logic             stalled;
    logic             busy;

    modport master (
        output en, pwm_in,
        input  period, high_time, duty, valid, stalled, busy
    );

    modport slave (
        input  en, pwm_in,
        output period, high_time, duty, valid, stalled, busy
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an incoming PWM in clk cycles and derives a 10-bit duty code.
// Optional macro PWM_CAPTURE_AVG_EN: duty becomes a 4-sample moving average and valid comes one cycle later.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic         clk,
    input  logic         rst,
    pwm_capture_if.slave bus
);
    typedef enum logic [1:0] {WAIT_EDGE, MEASURE, DIVIDE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_TMO   = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LAST_ITER = 4'd11;

    state_t           state;
    logic             sync1;
    logic             pwm_s;
    logic             pwm_d;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hi_inc;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_r;
    logic [CNT_W:0]   rem;
    logic [CNT_W:0]   den;
    logic [CNT_W:0]   trial;
    logic [CNT_W:0]   rem_next;
    logic             take;
    logic [10:0]      quo;
    logic [3:0]       iter;
    logic [9:0]       duty_raw;
    logic             tmo_block;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic [9:0]       duty_q;
    logic             valid_q;
    logic             stalled_q;
    logic             busy_q;

    assign rise    = pwm_s & ~pwm_d;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign hi_inc  = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + CNT_ONE;

    // high never exceeds period, so every quotient bit above 2^10 is zero: the remainder
    // starts at high itself and the first step compares without shifting.
    assign den      = {1'b0, period_r};
    assign trial    = (iter == 4'd0) ? rem : {rem[CNT_W-1:0], 1'b0};
    assign take     = (trial >= den);
    assign rem_next = take ? (trial - den) : trial;
    assign duty_raw = quo[10] ? 10'd1023 : quo[9:0];

`ifdef PWM_CAPTURE_AVG_EN
    logic [9:0]  hist0;
    logic [9:0]  hist1;
    logic [9:0]  hist2;
    logic [9:0]  hist3;
    logic        hist_empty;
    logic        avg_pend;
    logic [11:0] avg_sum;

    assign avg_sum   = {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2} + {2'b00, hist3};
    assign tmo_block = avg_pend;
`else
    assign tmo_block = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_EDGE;
            sync1     <= 1'b0;
            pwm_s     <= 1'b0;
            pwm_d     <= 1'b0;
            cnt       <= '0;
            hi_cnt    <= '0;
            period_r  <= '0;
            high_r    <= '0;
            rem       <= '0;
            quo       <= '0;
            iter      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef PWM_CAPTURE_AVG_EN
            hist0      <= '0;
            hist1      <= '0;
            hist2      <= '0;
            hist3      <= '0;
            hist_empty <= 1'b1;
            avg_pend   <= 1'b0;
`endif
        end else begin
            sync1   <= bus.pwm_in;
            pwm_s   <= sync1;
            pwm_d   <= pwm_s;
            valid_q <= 1'b0;
            if (!bus.en) begin
                state  <= WAIT_EDGE;
                cnt    <= '0;
                hi_cnt <= '0;
                iter   <= '0;
                busy_q <= 1'b0;
`ifdef PWM_CAPTURE_AVG_EN
                hist_empty <= 1'b1;
                avg_pend   <= 1'b0;
`endif
            end else begin
`ifdef PWM_CAPTURE_AVG_EN
                if (avg_pend) begin
                    avg_pend  <= 1'b0;
                    period_q  <= period_r;
                    high_q    <= high_r;
                    duty_q    <= avg_sum[11:2];
                    stalled_q <= 1'b0;
                    valid_q   <= 1'b1;
                end
`endif
                case (state)
                    WAIT_EDGE: begin
                        if (rise) begin
                            cnt    <= CNT_ONE;
                            hi_cnt <= CNT_ONE;
                            state  <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period_r <= cnt;
                            high_r   <= hi_cnt;
                            rem      <= {1'b0, hi_cnt};
                            quo      <= '0;
                            iter     <= '0;
                            busy_q   <= 1'b1;
                            cnt      <= CNT_ONE;
                            hi_cnt   <= CNT_ONE;
                            state    <= DIVIDE;
                        end else if (cnt >= CNT_TMO && !tmo_block) begin
                            // A stalled input reports its stuck level as 0% or 100% duty.
                            stalled_q <= 1'b1;
                            period_q  <= '0;
                            high_q    <= '0;
                            duty_q    <= pwm_s ? 10'd1023 : 10'd0;
                            valid_q   <= 1'b1;
                            cnt       <= '0;
                            hi_cnt    <= '0;
                            state     <= WAIT_EDGE;
`ifdef PWM_CAPTURE_AVG_EN
                            hist_empty <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt_inc;
                            if (pwm_s) begin
                                hi_cnt <= hi_inc;
                            end
                        end
                    end
                    DIVIDE: begin
                        // Counting continues so a sample dropped here leaves the next period intact.
                        if (rise) begin
                            cnt    <= CNT_ONE;
                            hi_cnt <= CNT_ONE;
                        end else begin
                            cnt <= cnt_inc;
                            if (pwm_s) begin
                                hi_cnt <= hi_inc;
                            end
                        end
                        if (iter == LAST_ITER) begin
`ifdef PWM_CAPTURE_AVG_EN
                            if (hist_empty) begin
                                hist0      <= duty_raw;
                                hist1      <= duty_raw;
                                hist2      <= duty_raw;
                                hist3      <= duty_raw;
                                hist_empty <= 1'b0;
                            end else begin
                                hist3 <= hist2;
                                hist2 <= hist1;
                                hist1 <= hist0;
                                hist0 <= duty_raw;
                            end
                            avg_pend <= 1'b1;
`else
                            period_q  <= period_r;
                            high_q    <= high_r;
                            duty_q    <= duty_raw;
                            stalled_q <= 1'b0;
                            valid_q   <= 1'b1;
`endif
                            busy_q <= 1'b0;
                            state  <= MEASURE;
                        end else begin
                            rem  <= rem_next;
                            quo  <= {quo[9:0], take};
                            iter <= iter + 4'd1;
                        end
                    end
                    default: state <= WAIT_EDGE;
                endcase
            end
        end
    end

    assign bus.period    = period_q;
    assign bus.high_time = high_q;
    assign bus.duty      = duty_q;
    assign bus.valid     = valid_q;
    assign bus.stalled   = stalled_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives directed PWM waveforms into pwm_capture and checks every output every cycle
// against an event-level measurement model, plus hand-computed literal results at key points.
module tb_pwm_capture;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 5000;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   gen_period  = 1;
    int   gen_high    = 0;
    int   gen_mode    = 2;
    int   gen_epoch   = 0;

    pwm_capture_if #(.CNT_W(CNT_W)) cap_if ();

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (cap_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 90000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkLiteral(input string tag, input int p, input int h, input int d, input int st);
        checkOutput({tag, ".period"}, 32'(cap_if.period), p);
        checkOutput({tag, ".high_time"}, 32'(cap_if.high_time), h);
        checkOutput({tag, ".duty"}, 32'(cap_if.duty), d);
        checkOutput({tag, ".stalled"}, 32'(cap_if.stalled), st);
    endtask

    task automatic applyStimulus(input bit r, input bit e, input int cycles);
        rst       = r;
        cap_if.en = e;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic setWave(input int p, input int h, input int mode);
        gen_period = p;
        gen_high   = h;
        gen_mode   = mode;
        gen_epoch++;
    endtask

    task automatic waitValid(input int maxc, input bit need_stall, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(posedge clk);
            #1;
            if (cap_if.valid && (!need_stall || cap_if.stalled)) got = 1'b1;
        end
    endtask

    task automatic countValids(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (cap_if.valid) n++;
        end
    endtask

    // Mode 0 free-running waveform restarted at phase 0 on every setWave; 1 held high; 2 held low.
    initial begin : wave_gen
        int phase;
        int seen;
        phase = 0;
        seen  = 0;
        cap_if.pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (gen_epoch != seen) begin
                seen  = gen_epoch;
                phase = 0;
            end
            case (gen_mode)
                0: begin
                    cap_if.pwm_in = (phase < gen_high);
                    phase = (phase + 1 >= gen_period) ? 0 : phase + 1;
                end
                1:       cap_if.pwm_in = 1'b1;
                default: cap_if.pwm_in = 1'b0;
            endcase
        end
    end

    function automatic int dutyOf(input int p, input int h);
        longint q;
        q = (longint'(h) * 1024) / longint'(p);
        return (q > 1023) ? 1023 : int'(q);
    endfunction

    bit m_h1, m_h2, m_h3, m_counting;
    int m_cnt, m_hi, m_pp, m_ph, m_edge;
    int m_done = -1;
    int e_period, e_high, e_duty;
    bit e_valid, e_stalled, e_busy;

    // Measurement model: the pin reaches the edge detector two clocks late; a rise while a
    // result is still 12 clocks from delivery is dropped but restarts the counts.
    always begin : ref_model
        bit s_rst, s_en, s_pin, m_rise, m_level, m_busy_now;
        @(posedge clk);
        s_rst = rst;
        s_en  = cap_if.en;
        s_pin = cap_if.pwm_in;
        m_edge++;
        if (s_rst) begin
            {m_h1, m_h2, m_h3, m_counting} = '0;
            m_cnt = 0; m_hi = 0; m_done = -1;
            e_period = 0; e_high = 0; e_duty = 0;
            e_valid = 0; e_stalled = 0;
        end else begin
            m_rise  = m_h2 && !m_h3;
            m_level = m_h2;
            e_valid = 0;
            if (!s_en) begin
                m_counting = 0; m_done = -1; m_cnt = 0; m_hi = 0;
            end else begin
                m_busy_now = (m_done >= 0);
                if (m_done == m_edge) begin
                    e_period = m_pp; e_high = m_ph; e_duty = dutyOf(m_pp, m_ph);
                    e_valid = 1; e_stalled = 0; m_done = -1;
                end
                if (!m_counting) begin
                    if (m_rise) begin m_counting = 1; m_cnt = 1; m_hi = 1; end
                end else if (m_rise) begin
                    if (!m_busy_now) begin m_pp = m_cnt; m_ph = m_hi; m_done = m_edge + 12; end
                    m_cnt = 1; m_hi = 1;
                end else if (!m_busy_now && m_cnt >= TIMEOUT) begin
                    e_period = 0; e_high = 0; e_duty = m_level ? 1023 : 0;
                    e_valid = 1; e_stalled = 1;
                    m_counting = 0; m_cnt = 0; m_hi = 0;
                end else begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (m_level && m_hi < CNT_MAX) m_hi++;
                end
            end
            m_h3 = m_h2; m_h2 = m_h1; m_h1 = s_pin;
        end
        e_busy = (m_done >= 0);
        #1;
        checkOutput("model.period", 32'(cap_if.period), e_period);
        checkOutput("model.high_time", 32'(cap_if.high_time), e_high);
        checkOutput("model.duty", 32'(cap_if.duty), e_duty);
        checkOutput("model.valid", 32'(cap_if.valid), 32'(e_valid));
        checkOutput("model.stalled", 32'(cap_if.stalled), 32'(e_stalled));
        checkOutput("model.busy", 32'(cap_if.busy), 32'(e_busy));
    end

    initial begin : stimulus
        bit got;
        int n;
        rst       = 1'b1;
        cap_if.en = 1'b0;
        applyStimulus(1'b1, 1'b0, 3);
        checkLiteral("reset", 0, 0, 0, 0);
        checkOutput("reset.valid", 32'(cap_if.valid), 0);
        checkOutput("reset.busy", 32'(cap_if.busy), 0);
        applyStimulus(1'b0, 1'b1, 2);

        $display("[TB] period 4000, high 2831");
        setWave(4000, 2831, 0);
        waitValid(12500, 1'b0, got);
        checkOutput("p4000.first_valid", 32'(got), 1);
        checkLiteral("p4000.first", 4000, 2831, 724, 0);
        waitValid(4100, 1'b0, got);
        checkOutput("p4000.second_valid", 32'(got), 1);
        checkLiteral("p4000.second", 4000, 2831, 724, 0);

        $display("[TB] period 100, high 50");
        setWave(100, 50, 0);
        for (int k = 0; k < 3; k++) waitValid(400, 1'b0, got);
        checkOutput("p100h50.valid", 32'(got), 1);
        checkLiteral("p100h50", 100, 50, 512, 0);

        $display("[TB] period 100, high 99");
        setWave(100, 99, 0);
        for (int k = 0; k < 3; k++) waitValid(400, 1'b0, got);
        checkOutput("p100h99.valid", 32'(got), 1);
        checkLiteral("p100h99", 100, 99, 1013, 0);

        $display("[TB] held high");
        setWave(100, 100, 0);
        waitValid(8000, 1'b1, got);
        checkOutput("held_hi.stall_valid", 32'(got), 1);
        checkLiteral("held_hi", 0, 0, 1023, 1);
        countValids(6000, n);
        checkOutput("held_hi.extra_valids", 32'(n), 0);

        $display("[TB] recovery, period 200, high 60");
        setWave(200, 60, 0);
        waitValid(700, 1'b0, got);
        checkOutput("recover.valid", 32'(got), 1);
        checkLiteral("recover", 200, 60, 307, 0);

        $display("[TB] held low");
        setWave(1, 0, 2);
        waitValid(8000, 1'b1, got);
        checkOutput("held_lo.stall_valid", 32'(got), 1);
        checkLiteral("held_lo", 0, 0, 0, 1);
        countValids(6000, n);
        checkOutput("held_lo.extra_valids", 32'(n), 0);

        $display("[TB] enable drop, period 300, high 100");
        setWave(300, 100, 0);
        waitValid(1000, 1'b0, got);
        checkOutput("en.valid_before", 32'(got), 1);
        checkLiteral("en.before", 300, 100, 341, 0);
        repeat (150) @(posedge clk);
        #2;
        cap_if.en = 1'b0;
        countValids(1000, n);
        checkOutput("en.low_valids", 32'(n), 0);
        checkLiteral("en.hold", 300, 100, 341, 0);
        checkOutput("en.hold.busy", 32'(cap_if.busy), 0);
        cap_if.en = 1'b1;
        waitValid(1000, 1'b0, got);
        checkOutput("en.valid_after", 32'(got), 1);
        checkLiteral("en.after", 300, 100, 341, 0);

        $display("[TB] reset while busy");
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(posedge clk);
            #1;
            if (cap_if.busy) got = 1'b1;
        end
        checkOutput("rst_busy.busy_seen", 32'(got), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkLiteral("rst_busy", 0, 0, 0, 0);
        checkOutput("rst_busy.valid", 32'(cap_if.valid), 0);
        checkOutput("rst_busy.busy", 32'(cap_if.busy), 0);
        rst = 1'b0;

        $display("[TB] period 10, high 4 (below minimum)");
        setWave(10, 4, 0);
        waitValid(200, 1'b0, got);
        waitValid(200, 1'b0, got);
        checkOutput("p10.valid", 32'(got), 1);
        checkLiteral("p10", 10, 4, 409, 0);
        repeat (300) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
